// File: rtl/e203_exu_alu_pipe.sv
// Single-stage ALU with a valid/ready request/response handshake and an independent
// bank of shared-buffer registers. One shared XLEN+1-bit adder serves add, subtract and all compares.
module e203_exu_alu_pipe #(
    parameter int XLEN  = 32,
    parameter int NSBF  = 2,
    parameter int SBF_W = 33,
    parameter int TAG_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [XLEN-1:0]       req_op1,
    input  logic [XLEN-1:0]       req_op2,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_res,
    output logic                  rsp_cmp,
    output logic [TAG_W-1:0]      rsp_tag,
    input  logic                  sbf_clr,
    input  logic [NSBF-1:0]       sbf_ena,
    input  logic [NSBF*SBF_W-1:0] sbf_nxt,
    output logic [NSBF*SBF_W-1:0] sbf_r
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_XOR  = 4'd2,  OP_OR   = 4'd3,
        OP_AND  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_LUI  = 4'd10, OP_MAX  = 4'd11,
        OP_MIN  = 4'd12, OP_MAXU = 4'd13, OP_MINU = 4'd14, OP_EQ   = 4'd15
    } op_e;

    op_e              op;
    logic             use_sub;
    logic             sign_ext;
    logic [XLEN:0]    a_ext;
    logic [XLEN:0]    b_ext;
    logic [XLEN:0]    sum;
    logic             lt;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  res_d;
    logic             cmp_d;
    logic             accept;

    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_res_q;
    logic             rsp_cmp_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [SBF_W-1:0] sbf_q [NSBF];

    assign op        = op_e'(req_op);
    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign shamt     = req_op2[SHW-1:0];

    // The extra top bit of the difference is the signed or unsigned "less than" flag.
    assign use_sub  = (op != OP_ADD);
    assign sign_ext = (op == OP_SUB) || (op == OP_SLT) || (op == OP_MAX) || (op == OP_MIN);
    assign a_ext    = {sign_ext & req_op1[XLEN-1], req_op1};
    assign b_ext    = {sign_ext & req_op2[XLEN-1], req_op2};
    assign sum      = a_ext + (use_sub ? ~b_ext : b_ext) + {{XLEN{1'b0}}, use_sub};
    assign lt       = sum[XLEN];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        res_d = '0;
        cmp_d = 1'b0;
        case (op)
            OP_ADD, OP_SUB:   res_d = sum[XLEN-1:0];
            OP_XOR:           res_d = req_op1 ^ req_op2;
            OP_OR:            res_d = req_op1 | req_op2;
            OP_AND:           res_d = req_op1 & req_op2;
            OP_SLL:           res_d = req_op1 << shamt;
            OP_SRL:           res_d = req_op1 >> shamt;
            OP_SRA:           res_d = $unsigned($signed(req_op1) >>> shamt);
            OP_SLT, OP_SLTU: begin
                cmp_d = lt;
                res_d = {{(XLEN-1){1'b0}}, lt};
            end
            OP_LUI:           res_d = req_op2;
            OP_MAX, OP_MAXU:  res_d = lt ? req_op2 : req_op1;
            OP_MIN, OP_MINU:  res_d = lt ? req_op1 : req_op2;
            OP_EQ: begin
                cmp_d = (req_op1 == req_op2);
                res_d = {{(XLEN-1){1'b0}}, cmp_d};
            end
            default:          res_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_cmp_q   <= 1'b0;
            rsp_tag_q   <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_res_q   <= res_d;
            rsp_cmp_q   <= cmp_d;
            rsp_tag_q   <= req_tag;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cmp   = rsp_cmp_q;
    assign rsp_tag   = rsp_tag_q;

    // NOTE: the buffer array is a handful of registers that must read zero in reset, so it is reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSBF; i++) sbf_q[i] <= '0;
        end else if (sbf_clr) begin
            for (int i = 0; i < NSBF; i++) sbf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSBF; i++) begin
                if (sbf_ena[i]) sbf_q[i] <= sbf_nxt[i*SBF_W +: SBF_W];
            end
        end
    end

    for (genvar g = 0; g < NSBF; g++) begin : g_sbf_out
        assign sbf_r[g*SBF_W +: SBF_W] = sbf_q[g];
    end

endmodule

// File: tb/tb_e203_exu_alu_pipe.sv
// Drives a 32-bit and a 64-bit instance in lockstep and compares both against a
// behavioural ALU/handshake/buffer model kept in the bench.
module tb_e203_exu_alu_pipe;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         rsp_ready;
    logic [3:0]   req_op;
    logic [1:0]   req_tag;
    logic         sbf_clr;

    logic [31:0]  a_op1, a_op2, a_rsp_res;
    logic         a_req_ready, a_rsp_valid, a_rsp_cmp;
    logic [1:0]   a_rsp_tag;
    logic [1:0]   a_sbf_ena;
    logic [65:0]  a_sbf_nxt, a_sbf_r;

    logic [63:0]  b_op1, b_op2, b_rsp_res;
    logic         b_req_ready, b_rsp_valid, b_rsp_cmp;
    logic [1:0]   b_rsp_tag;
    logic [3:0]   b_sbf_ena;
    logic [259:0] b_sbf_nxt, b_sbf_r;

    // Reference state
    logic         ev;
    logic [31:0]  a_eres;
    logic         a_ecmp;
    logic [63:0]  b_eres;
    logic         b_ecmp;
    logic [1:0]   etag;
    logic [65:0]  a_sbf_m;
    logic [259:0] b_sbf_m;

    int compared = 0;
    int mism     = 0;

    e203_exu_alu_pipe #(.XLEN(32), .NSBF(2), .SBF_W(33), .TAG_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_op(req_op),
        .req_op1(a_op1), .req_op2(a_op2), .req_tag(req_tag),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(a_rsp_res),
        .rsp_cmp(a_rsp_cmp), .rsp_tag(a_rsp_tag),
        .sbf_clr(sbf_clr), .sbf_ena(a_sbf_ena), .sbf_nxt(a_sbf_nxt), .sbf_r(a_sbf_r)
    );

    e203_exu_alu_pipe #(.XLEN(64), .NSBF(4), .SBF_W(65), .TAG_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_op(req_op),
        .req_op1(b_op1), .req_op2(b_op2), .req_tag(req_tag),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_res(b_rsp_res),
        .rsp_cmp(b_rsp_cmp), .rsp_tag(b_rsp_tag),
        .sbf_clr(sbf_clr), .sbf_ena(b_sbf_ena), .sbf_nxt(b_sbf_nxt), .sbf_r(b_sbf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {cmp, result} for a 32- or 64-bit ALU, using plain integer arithmetic.
    function automatic logic [64:0] ref_alu(input int xlen, input logic [3:0] op,
                                            input logic [63:0] xi, input logic [63:0] yi);
        logic [63:0] mask, x, y, r;
        longint      sx, sy;
        logic        f;
        int          sh;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        x    = xi & mask;
        y    = yi & mask;
        sx   = (xlen == 64) ? longint'(x) : longint'($signed(x[31:0]));
        sy   = (xlen == 64) ? longint'(y) : longint'($signed(y[31:0]));
        sh   = int'(y & 64'(xlen - 1));
        f    = 1'b0;
        r    = '0;
        case (op)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x ^ y;
            4'd3:  r = x | y;
            4'd4:  r = x & y;
            4'd5:  r = x << sh;
            4'd6:  r = x >> sh;
            4'd7:  r = 64'(sx >>> sh);
            4'd8:  begin f = (sx < sy); r = {63'd0, f}; end
            4'd9:  begin f = (x < y);   r = {63'd0, f}; end
            4'd10: r = y;
            4'd11: r = (sx >= sy) ? x : y;
            4'd12: r = (sx <= sy) ? x : y;
            4'd13: r = (x >= y) ? x : y;
            4'd14: r = (x <= y) ? x : y;
            default: begin f = (x == y); r = {63'd0, f}; end
        endcase
        return {f, r & mask};
    endfunction

    task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        logic        acc;
        logic [64:0] ra, rb;
        #1;
        chk("req_ready_a", 264'(a_req_ready), 264'(!ev || rsp_ready));
        chk("req_ready_b", 264'(b_req_ready), 264'(!ev || rsp_ready));
        acc = req_valid && (!ev || rsp_ready);
        ra  = ref_alu(32, req_op, {32'd0, a_op1}, {32'd0, a_op2});
        rb  = ref_alu(64, req_op, b_op1, b_op2);
        if (acc) begin
            ev     = 1'b1;
            a_eres = ra[31:0];
            a_ecmp = ra[64];
            b_eres = rb[63:0];
            b_ecmp = rb[64];
            etag   = req_tag;
        end else if (rsp_ready) begin
            ev = 1'b0;
        end
        if (sbf_clr) begin
            a_sbf_m = '0;
            b_sbf_m = '0;
        end else begin
            for (int i = 0; i < 2; i++) if (a_sbf_ena[i]) a_sbf_m[i*33 +: 33] = a_sbf_nxt[i*33 +: 33];
            for (int i = 0; i < 4; i++) if (b_sbf_ena[i]) b_sbf_m[i*65 +: 65] = b_sbf_nxt[i*65 +: 65];
        end
        @(posedge clk);
        #1;
        chk("rsp_valid_a", 264'(a_rsp_valid), 264'(ev));
        chk("rsp_valid_b", 264'(b_rsp_valid), 264'(ev));
        if (ev) begin
            chk("rsp_res_a", 264'(a_rsp_res), 264'(a_eres));
            chk("rsp_cmp_a", 264'(a_rsp_cmp), 264'(a_ecmp));
            chk("rsp_tag_a", 264'(a_rsp_tag), 264'(etag));
            chk("rsp_res_b", 264'(b_rsp_res), 264'(b_eres));
            chk("rsp_cmp_b", 264'(b_rsp_cmp), 264'(b_ecmp));
            chk("rsp_tag_b", 264'(b_rsp_tag), 264'(etag));
        end
        chk("sbf_r_a", 264'(a_sbf_r), 264'(a_sbf_m));
        chk("sbf_r_b", 264'(b_sbf_r), 264'(b_sbf_m));
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid_a"}, 264'(a_rsp_valid), 264'(0));
        chk({tag, "_res_a"},   264'(a_rsp_res),   264'(0));
        chk({tag, "_cmp_a"},   264'(a_rsp_cmp),   264'(0));
        chk({tag, "_tag_a"},   264'(a_rsp_tag),   264'(0));
        chk({tag, "_sbf_a"},   264'(a_sbf_r),     264'(0));
        chk({tag, "_valid_b"}, 264'(b_rsp_valid), 264'(0));
        chk({tag, "_res_b"},   264'(b_rsp_res),   264'(0));
        chk({tag, "_sbf_b"},   264'(b_sbf_r),     264'(0));
    endtask

    initial begin
        logic [287:0] wide_rnd;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        req_op    = 4'd0;
        req_tag   = 2'd0;
        sbf_clr   = 1'b0;
        a_op1 = '0; a_op2 = '0; b_op1 = '0; b_op2 = '0;
        a_sbf_ena = '0; a_sbf_nxt = '0; b_sbf_ena = '0; b_sbf_nxt = '0;
        ev = 1'b0; a_eres = '0; a_ecmp = 1'b0; b_eres = '0; b_ecmp = 1'b0; etag = '0;
        a_sbf_m = '0; b_sbf_m = '0;

        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // ADD wrap-around, accepted on the first edge after reset release
        req_valid = 1'b1; req_op = 4'd0; req_tag = 2'd2;
        a_op1 = 32'hFFFF_FFFF; a_op2 = 32'd1;
        b_op1 = 64'hFFFF_FFFF_FFFF_FFFF; b_op2 = 64'd1;
        step();
        chk("add_wrap_res", 264'(a_rsp_res), 264'(32'h0));
        chk("add_wrap_tag", 264'(a_rsp_tag), 264'(2));

        // SRA / SLT / SLTU back to back
        req_op = 4'd7; req_tag = 2'd1;
        a_op1 = 32'h8000_0000; a_op2 = 32'h24;
        b_op1 = 64'h8000_0000_0000_0000; b_op2 = 64'h24;
        step();
        chk("sra_res", 264'(a_rsp_res), 264'(32'hF800_0000));
        req_op = 4'd8; a_op1 = 32'hFFFF_FFFF; a_op2 = 32'd1;
        b_op1 = 64'hFFFF_FFFF_FFFF_FFFF; b_op2 = 64'd1;
        step();
        chk("slt_res", 264'(a_rsp_res), 264'(32'h1));
        chk("slt_cmp", 264'(a_rsp_cmp), 264'(1));
        req_op = 4'd9;
        step();
        chk("sltu_res", 264'(a_rsp_res), 264'(32'h0));
        chk("sltu_cmp", 264'(a_rsp_cmp), 264'(0));

        // Backpressure: MINU 5,3 then MAX waits three cycles
        req_op = 4'd14; a_op1 = 32'd5; a_op2 = 32'd3; b_op1 = 64'd5; b_op2 = 64'd3;
        step();
        rsp_ready = 1'b0;
        req_op = 4'd11; a_op1 = 32'h8000_0000; a_op2 = 32'd1;
        b_op1 = 64'h8000_0000_0000_0000; b_op2 = 64'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_res", 264'(a_rsp_res), 264'(3));
            chk("bp_ready_low", 264'(a_req_ready), 264'(0));
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_res", 264'(a_rsp_res), 264'(1));
        req_valid = 1'b0;
        step();

        // Shared buffers: load all, then clear beats enable
        a_sbf_ena = 2'b11;
        a_sbf_nxt = {33'h0_0000_0001, 33'h1_2345_6789};
        b_sbf_ena = 4'hF;
        b_sbf_nxt = {65'h1_0000_0000_0000_0001, 65'h0_DEAD_BEEF_0000_0001,
                     65'h0_0000_0000_0000_0001, 65'h1_2345_6789_ABCD_EF01};
        step();
        chk("sbf_load_a", 264'(a_sbf_r), 264'({33'h0_0000_0001, 33'h1_2345_6789}));
        sbf_clr = 1'b1; a_sbf_ena = 2'b01; b_sbf_ena = 4'b0001;
        step();
        chk("sbf_clr_a", 264'(a_sbf_r), 264'(0));
        chk("sbf_clr_b", 264'(b_sbf_r), 264'(0));
        sbf_clr = 1'b0; a_sbf_ena = '0; b_sbf_ena = '0;

        // Asynchronous reset while a result is pending
        req_valid = 1'b1; req_op = 4'd3; rsp_ready = 1'b0;
        a_sbf_ena = 2'b11; b_sbf_ena = 4'hF;
        step();
        req_valid = 1'b0; a_sbf_ena = '0; b_sbf_ena = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        ev = 1'b0; a_sbf_m = '0; b_sbf_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 4'd1; req_tag = 2'd3;
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            rsp_ready = ($urandom_range(0, 9) < 7);
            req_op    = 4'($urandom_range(0, 15));
            req_tag   = 2'($urandom());
            a_op1     = $urandom();
            a_op2     = $urandom();
            b_op1     = {$urandom(), $urandom()};
            b_op2     = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) begin
                a_op2 = a_op1;
                b_op2 = b_op1;
            end
            sbf_clr   = ($urandom_range(0, 19) == 0);
            a_sbf_ena = 2'($urandom());
            b_sbf_ena = 4'($urandom());
            for (int k = 0; k < 9; k++) wide_rnd[k*32 +: 32] = $urandom();
            a_sbf_nxt = wide_rnd[65:0];
            b_sbf_nxt = wide_rnd[259:0];
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
